mem_dbus_bridge: RTL and testbench
==================================

MEM_DBUS_BRIDGE -- requirements
Module: mem_dbus_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, giving the address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the data width; STRB_W is fixed at DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset (asserted when 0).
REQ-005 The block SHALL have ports RamReadEnable (in, 1), RamReadAddr (in, ADDR_W) and RamWriteEnable (in, 1), RamWriteAddr (in, ADDR_W), RamWriteData (in, DATA_W), RamWriteMask (in, DATA_W), all as driven by the memory stage.
REQ-006 The block SHALL have port RamReadDataM, output, DATA_W, the full aligned doubleword returned to the memory stage.
REQ-007 The block SHALL have port mem_stall, output, 1, which holds the memory stage and all upstream pipeline registers while high.
REQ-008 The block SHALL have ports bus_req_valid (out, 1), bus_req_ready (in, 1), bus_req_write (out, 1), bus_req_addr (out, ADDR_W), bus_req_wdata (out, DATA_W), bus_req_wstrb (out, STRB_W).
REQ-009 The block SHALL have ports bus_rsp_valid (in, 1), bus_rsp_rdata (in, DATA_W), bus_rsp_err (in, 1), and bus_err (out, 1, sticky error flag).

Function
REQ-010 The block SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-011 In IDLE with RamReadEnable=1, the next state SHALL be RD_REQ; with only RamWriteEnable=1, WR_REQ; with neither, IDLE.
REQ-012 mem_stall SHALL be 1 combinationally in IDLE when either enable is 1, and 1 in every state except IDLE and DONE.
REQ-013 Request payload (addr, write, wdata, wstrb) SHALL be registered on leaving IDLE; bus_req_valid SHALL be 1 exactly in RD_REQ and WR_REQ.
REQ-014 bus_req_addr SHALL be the relevant input address with bits [2:0] forced to 0.
REQ-015 bus_req_wstrb[i] SHALL equal RamWriteMask[8*i]; bus_req_wdata SHALL equal RamWriteData; for reads both SHALL be 0 and bus_req_write 0.
REQ-016 Payload and bus_req_valid SHALL remain stable while bus_req_valid=1 and bus_req_ready=0.
REQ-017 On bus_req_valid & bus_req_ready, RD_REQ SHALL go to RD_WAIT and WR_REQ to WR_WAIT.
REQ-018 In RD_WAIT on bus_rsp_valid, bus_rsp_rdata SHALL be captured into RamReadDataM; next state WR_REQ if a write is also pending, else DONE.
REQ-019 In WR_WAIT on bus_rsp_valid, next state SHALL be DONE; rdata ignored.
REQ-020 Simultaneous read and write enables SHALL issue the read first, then the write, with mem_stall held throughout.
REQ-021 bus_rsp_valid outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-022 DONE SHALL last exactly one cycle with mem_stall=0, then return to IDLE unconditionally, so the same request is never reissued.
REQ-023 RamReadDataM SHALL hold its last captured value until the next read response.
REQ-024 bus_err SHALL set on bus_rsp_valid & bus_rsp_err in a WAIT state and clear only on reset; the transaction still completes normally.

Reset
REQ-025 While rst=0: state IDLE, bus_req_valid 0, mem_stall 0, RamReadDataM 0, bus_err 0, all payload registers 0.
REQ-026 Reset asserted mid-transaction SHALL abort immediately; no response is awaited after release.
REQ-027 After rst returns to 1, first request SHALL be accepted on the next rising edge.

Verification
REQ-028 Read addr 0x8000_0013, ready=1, rsp after 2 cycles rdata 0x1122334455667788 -> bus_req_addr 0x8000_0010, write 0, stall 4 cycles, RamReadDataM 0x1122334455667788 in DONE.
REQ-029 Write addr 0x8000_0004, mask 0xFFFF_FFFF_0000_0000, data 0xAABBCCDD_00000000 -> wstrb 0xF0, addr 0x8000_0000, one bus transaction.
REQ-030 bus_req_ready held 0 for 5 cycles -> valid and payload stable all 5 cycles, single handshake.
REQ-031 Read+write same cycle -> exactly two handshakes, read then write, stall continuous until DONE.
REQ-032 rsp_err=1 on a read -> bus_err 1 persisting through later clean transactions; rst=0 mid-RD_WAIT -> IDLE, valid 0, bus_err 0.

Source files
------------

// File: rtl/mem_dbus_bridge_if.sv
// Request/response data bus between the memory-stage bridge (master) and the
// data-bus fabric (slave).
interface mem_dbus_bridge_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_write;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic [STRB_W-1:0] bus_req_wstrb;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rsp_rdata;
  logic              bus_rsp_err;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );
endinterface

// File: rtl/mem_dbus_bridge.sv
// Bridges the pipeline memory-stage RAM port onto a valid/ready data bus,
// stalling the pipeline until each doubleword transaction completes.
module mem_dbus_bridge #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RamReadEnable,
  input  logic [ADDR_W-1:0] RamReadAddr,
  input  logic              RamWriteEnable,
  input  logic [ADDR_W-1:0] RamWriteAddr,
  input  logic [DATA_W-1:0] RamWriteData,
  input  logic [DATA_W-1:0] RamWriteMask,
  output logic [DATA_W-1:0] RamReadDataM,
  output logic              mem_stall,
  mem_dbus_bridge_if.master bus,
  output logic              bus_err
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              req_write_q, req_write_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0] req_wstrb_q, req_wstrb_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_wdata_q, wr_wdata_d;
  logic [STRB_W-1:0] wr_wstrb_q, wr_wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [STRB_W-1:0] wr_strb_in;
  logic [ADDR_W-1:0] rd_addr_al, wr_addr_al;

  // Only the low bit of each mask byte and the doubleword address bits matter.
  logic unused_bits;
  assign unused_bits = ^{RamWriteMask, RamReadAddr[2:0], RamWriteAddr[2:0]};

  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    wr_pend_d   = wr_pend_q;
    wr_addr_d   = wr_addr_q;
    wr_wdata_d  = wr_wdata_q;
    wr_wstrb_d  = wr_wstrb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    wr_strb_in = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      wr_strb_in[i] = RamWriteMask[8*i];
    end
    rd_addr_al = {RamReadAddr[ADDR_W-1:3], 3'b000};
    wr_addr_al = {RamWriteAddr[ADDR_W-1:3], 3'b000};

    unique case (state_q)
      IDLE: begin
        // Write payload is parked so a write following a read needs no re-sampling.
        if (RamReadEnable || RamWriteEnable) begin
          wr_pend_d  = RamReadEnable & RamWriteEnable;
          wr_addr_d  = wr_addr_al;
          wr_wdata_d = RamWriteData;
          wr_wstrb_d = wr_strb_in;
        end
        if (RamReadEnable) begin
          state_d     = RD_REQ;
          req_write_d = 1'b0;
          req_addr_d  = rd_addr_al;
          req_wdata_d = '0;
          req_wstrb_d = '0;
        end else if (RamWriteEnable) begin
          state_d     = WR_REQ;
          req_write_d = 1'b1;
          req_addr_d  = wr_addr_al;
          req_wdata_d = RamWriteData;
          req_wstrb_d = wr_strb_in;
        end
      end
      RD_REQ: if (bus.bus_req_ready) state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.bus_rsp_valid) begin
          rdata_d = bus.bus_rsp_rdata;
          if (bus.bus_rsp_err) err_d = 1'b1;
          wr_pend_d = 1'b0;
          if (wr_pend_q) begin
            state_d     = WR_REQ;
            req_write_d = 1'b1;
            req_addr_d  = wr_addr_q;
            req_wdata_d = wr_wdata_q;
            req_wstrb_d = wr_wstrb_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      WR_REQ: if (bus.bus_req_ready) state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.bus_rsp_valid) begin
          if (bus.bus_rsp_err) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
    bus.bus_req_write = req_write_q;
    bus.bus_req_addr  = req_addr_q;
    bus.bus_req_wdata = req_wdata_q;
    bus.bus_req_wstrb = req_wstrb_q;
    RamReadDataM      = rdata_q;
    bus_err           = err_q;
    // Stall is forced low while reset is held even if enables are asserted.
    if (!rst) begin
      mem_stall = 1'b0;
    end else if (state_q == IDLE) begin
      mem_stall = RamReadEnable | RamWriteEnable;
    end else begin
      mem_stall = (state_q != DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_wdata_q  <= '0;
      wr_wstrb_q  <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_wdata_q  <= wr_wdata_d;
      wr_wstrb_q  <= wr_wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_dbus_bridge.sv
// Randomized scoreboard bench for mem_dbus_bridge: a memory-stage driver queues
// expected bus requests, a bus-slave monitor pops and checks them.
module tb_mem_dbus_bridge;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          RamReadEnable, RamWriteEnable;
  logic [AW-1:0] RamReadAddr, RamWriteAddr;
  logic [DW-1:0] RamWriteData, RamWriteMask, RamReadDataM;
  logic          mem_stall, bus_err;

  always #5 clk = ~clk;

  mem_dbus_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  mem_dbus_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .RamReadEnable (RamReadEnable),
    .RamReadAddr   (RamReadAddr),
    .RamWriteEnable(RamWriteEnable),
    .RamWriteAddr  (RamWriteAddr),
    .RamWriteData  (RamWriteData),
    .RamWriteMask  (RamWriteMask),
    .RamReadDataM  (RamReadDataM),
    .mem_stall     (mem_stall),
    .bus           (bif),
    .bus_err       (bus_err)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  req_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] model_rd = '0;
  logic          model_err = 1'b0;

  // Slave behaviour knobs
  bit            ready_always = 0;
  int            ready_hold = 0;
  int            fix_delay = -1;
  bit            no_rsp = 0;
  bit            force_err = 0;
  bit            rand_err = 1;
  bit            spurious_en = 1;
  bit            fix_rdata_en = 0;
  logic [DW-1:0] fix_rdata = '0;

  int            rsp_cnt = -1;
  bit            rsp_is_read = 0;
  int            handshakes = 0;
  int            stab_checks = 0;
  bit            prev_pending = 0;
  req_t          prev_req;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // Bus slave + monitor: acts mid-cycle so everything it drives is settled by the edge.
  always @(negedge clk) begin
    req_t          r;
    req_t          cur;
    logic [DW-1:0] d;
    logic          e;
    if (!rst) begin
      bif.bus_req_ready = 1'b0;
      bif.bus_rsp_valid = 1'b0;
      bif.bus_rsp_err   = 1'b0;
      rsp_cnt = -1;
      prev_pending = 0;
    end else begin
      bif.bus_rsp_valid = 1'b0;
      bif.bus_rsp_err   = 1'b0;
      bif.bus_rsp_rdata = {$urandom, $urandom};
      if (rsp_cnt == 0) begin
        d = fix_rdata_en ? fix_rdata : {$urandom, $urandom};
        e = force_err | (rand_err && ($urandom % 8 == 0));
        bif.bus_rsp_valid = 1'b1;
        bif.bus_rsp_rdata = d;
        bif.bus_rsp_err   = e;
        if (rsp_is_read) model_rd = d;
        if (e) model_err = 1'b1;
        rsp_cnt = -1;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end else if (spurious_en && ($urandom % 6 == 0)) begin
        bif.bus_rsp_valid = 1'b1;
        bif.bus_rsp_err   = 1'b1;
      end

      cur.write = bif.bus_req_write;
      cur.addr  = bif.bus_req_addr;
      cur.wdata = bif.bus_req_wdata;
      cur.wstrb = bif.bus_req_wstrb;
      if (prev_pending) begin
        stab_checks++;
        chk("valid_held", bif.bus_req_valid, 1);
        chk("stable_addr", cur.addr, prev_req.addr);
        chk("stable_wdata", cur.wdata, prev_req.wdata);
        chk("stable_wr_strb", {cur.write, cur.wstrb}, {prev_req.write, prev_req.wstrb});
      end
      if (bif.bus_req_valid) begin
        if (ready_hold > 0) begin
          bif.bus_req_ready = 1'b0;
          ready_hold--;
        end else begin
          bif.bus_req_ready = ready_always ? 1'b1 : ($urandom % 3 != 0);
        end
        if (bif.bus_req_ready) begin
          handshakes++;
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
          end else begin
            r = exp_q.pop_front();
            chk("req_write", cur.write, r.write);
            chk("req_addr", cur.addr, r.addr);
            chk("req_wdata", cur.wdata, r.wdata);
            chk("req_wstrb", cur.wstrb, r.wstrb);
          end
          rsp_is_read = !cur.write;
          rsp_cnt = no_rsp ? 1000000 : (fix_delay >= 0 ? fix_delay : int'($urandom % 4));
        end
        prev_pending = !bif.bus_req_ready;
        prev_req = cur;
      end else begin
        bif.bus_req_ready = $urandom % 2;
        prev_pending = 0;
      end
    end
  end

  task automatic drop_inputs();
    RamReadEnable  = 1'b0;
    RamWriteEnable = 1'b0;
    RamReadAddr    = {$urandom, $urandom};
    RamWriteAddr   = {$urandom, $urandom};
    RamWriteData   = {$urandom, $urandom};
    RamWriteMask   = {$urandom, $urandom};
  endtask

  // Memory-stage driver; must be entered with the DUT idle, 1 time unit after an edge.
  task automatic do_op(input bit re, input bit we, input logic [63:0] ra, input logic [63:0] wa,
                       input logic [63:0] wd, input logic [63:0] wm, output int cyc);
    req_t r;
    bit   done;
    if (re) begin
      r.write = 1'b0; r.addr = {ra[63:3], 3'b000}; r.wdata = '0; r.wstrb = '0;
      exp_q.push_back(r);
    end
    if (we) begin
      r.write = 1'b1; r.addr = {wa[63:3], 3'b000}; r.wdata = wd;
      for (int i = 0; i < 8; i++) r.wstrb[i] = wm[8*i];
      exp_q.push_back(r);
    end
    RamReadEnable = re; RamWriteEnable = we;
    RamReadAddr = ra; RamWriteAddr = wa; RamWriteData = wd; RamWriteMask = wm;
    #1;
    chk("stall_in_idle", mem_stall, 1);
    cyc = 1;
    @(posedge clk); #1;
    chk("valid_next_edge", bif.bus_req_valid, 1);
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (!mem_stall) done = 1;
      else begin
        cyc++;
        @(posedge clk); #1;
      end
    end
    chk("op_completes", done, 1);
    chk("done_valid_low", bif.bus_req_valid, 0);
    chk("rd_data", RamReadDataM, model_rd);
    chk("bus_err", bus_err, model_err);
    chk("reqs_outstanding", exp_q.size(), 0);
    chk("rsp_outstanding", rsp_cnt + 1, 0);
    drop_inputs();
    @(posedge clk); #1;
    chk("idle_stall_low", mem_stall, 0);
    chk("idle_valid_low", bif.bus_req_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc;
    int            hs0;
    int            st0;
    bit            re, we;
    logic [63:0]   m;
    bit            got;

    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_rdata = '0;
    bif.bus_rsp_err   = 1'b0;
    drop_inputs();
    rst = 1'b0;
    RamReadEnable = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", mem_stall, 0);
    chk("rst_valid", bif.bus_req_valid, 0);
    chk("rst_rdata", RamReadDataM, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_addr", bif.bus_req_addr, 0);
    chk("rst_wdata", bif.bus_req_wdata, 0);
    chk("rst_wr_strb", {bif.bus_req_write, bif.bus_req_wstrb}, 0);
    drop_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed read: zero-wait ready, response on the second WAIT cycle
    ready_always = 1; fix_delay = 1; spurious_en = 0; rand_err = 0;
    fix_rdata_en = 1; fix_rdata = 64'h1122334455667788;
    do_op(1, 0, 64'h8000_0013, 0, 0, 0, cyc);
    chk("rd_stall_cycles", cyc, 4);
    chk("rd_data_fixed", RamReadDataM, 64'h1122334455667788);
    fix_rdata_en = 0;

    // Directed write with upper-half mask
    hs0 = handshakes;
    do_op(0, 1, 0, 64'h8000_0004, 64'hAABBCCDD_00000000, 64'hFFFF_FFFF_0000_0000, cyc);
    chk("wr_handshakes", handshakes - hs0, 1);

    // Backpressure: ready held low for five cycles
    hs0 = handshakes; st0 = stab_checks; fix_delay = 0; ready_hold = 5;
    do_op(1, 0, {$urandom, $urandom}, 0, 0, 0, cyc);
    chk("bp_handshakes", handshakes - hs0, 1);
    chk("bp_stable_cycles", stab_checks - st0, 5);
    chk("bp_stall_cycles", cyc, 8);

    // Simultaneous read and write
    hs0 = handshakes;
    do_op(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          64'h00FF_00FF_FF00_FF00, cyc);
    chk("rw_handshakes", handshakes - hs0, 2);
    chk("rw_stall_cycles", cyc, 5);

    // Error response is sticky across clean transactions
    force_err = 1;
    do_op(1, 0, {$urandom, $urandom}, 0, 0, 0, cyc);
    chk("err_set", bus_err, 1);
    force_err = 0; spurious_en = 1; ready_always = 0; fix_delay = -1;
    for (int n = 0; n < 4; n++) begin
      do_op(n[0], !n[0], {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, cyc);
      chk("err_sticky", bus_err, 1);
    end

    // Reset during RD_WAIT aborts the transaction and clears the error flag
    spurious_en = 0; no_rsp = 1; ready_always = 1;
    hs0 = handshakes;
    r_issue: begin
      req_t r;
      r.write = 1'b0; RamReadAddr = {$urandom, $urandom};
      r.addr = {RamReadAddr[63:3], 3'b000}; r.wdata = '0; r.wstrb = '0;
      exp_q.push_back(r);
      RamReadEnable = 1'b1;
    end
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk); #1;
      if (handshakes != hs0) got = 1;
    end
    chk("abort_handshake_seen", got, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_valid", bif.bus_req_valid, 0);
    chk("abort_stall", mem_stall, 0);
    chk("abort_err", bus_err, 0);
    chk("abort_rdata", RamReadDataM, 0);
    drop_inputs();
    exp_q.delete();
    model_err = 1'b0; model_rd = '0; no_rsp = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    ready_always = 0; rand_err = 1; spurious_en = 1;
    do_op(1, 0, {$urandom, $urandom}, 0, 0, 0, cyc);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom % 3)
        0: begin re = 1; we = 0; end
        1: begin re = 0; we = 1; end
        default: begin re = 1; we = 1; end
      endcase
      m = '0;
      if ($urandom % 5 == 0) m = {$urandom, $urandom};
      else for (int b = 0; b < 8; b++) if ($urandom % 2) m[8*b +: 8] = 8'hFF;
      do_op(re, we, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, m, cyc);
      repeat ($urandom % 3) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
